instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//   Requester side of the instruction-memory read port: owns the program counter, drives PC_out to
//   instruction_memory, and captures the returned IR_out word into a registered fetch slot.
//   Sits between instruction memory and decode. Supports decode back-pressure,
//   branch redirect/flush from execute, and a halt at end of program.
// PARAMETERS
//   ADDR_W    4    PC width in words; matches the instruction-memory depth (2**ADDR_W words)
//   DATA_W    32   instruction width
//   PROG_LEN  8    number of valid program words (1..2**ADDR_W); fetch of word PROG_LEN-1 ends the run
// PORTS
//   clk            in   1       clock; all state updates on rising edge
//   reset_n        in   1       synchronous, active-low reset
//   start          in   1       begin fetching from PC 0 (sampled in IDLE only)
//   PC_out         out  ADDR_W  word address to instruction memory (registered PC)
//   IR_out         in   DATA_W  instruction word from memory; combinational function of PC_out
//   dec_valid      out  1       fetch slot holds an instruction for decode
//   dec_instr      out  DATA_W  captured instruction
//   dec_pc         out  ADDR_W  address the captured instruction came from
//   dec_ready      in   1       decode accepts dec_instr this cycle (transfer = dec_valid & dec_ready)
//   branch_taken   in   1       execute redirects fetch this cycle
//   branch_target  in   ADDR_W  redirect word address
//   halted         out  1       fetch has stopped (end of program or out-of-range target)
// BEHAVIOUR
//   Reset (reset_n=0 at edge): state=IDLE, PC_out=0, dec_valid=0, dec_instr=0, dec_pc=0, halted=0.
//     Reset has priority over all inputs and aborts any fetch/stall/halt in progress.
//   States: IDLE, RUN, HALTED.
//   IDLE: outputs hold reset values; start=1 -> RUN next cycle (PC_out stays 0). branch_taken ignored.
//   RUN, slot free (dec_valid=0 or dec_ready=1) and no branch:
//     dec_instr<=IR_out, dec_pc<=PC_out, dec_valid<=1, PC_out<=PC_out+1 (mod 2**ADDR_W).
//     Latency: a word appears on dec_instr one cycle after its address is on PC_out.
//     If captured PC_out==PROG_LEN-1: PC_out holds, state->HALTED, halted<=1 the same edge.
//   RUN, stall (dec_valid=1 and dec_ready=0): PC_out, dec_instr, dec_pc, dec_valid all hold; no capture.
//   branch_taken=1 in RUN (priority over capture and stall):
//     if branch_target<PROG_LEN: PC_out<=branch_target, dec_valid<=0 (flush), stay RUN;
//     else: PC_out<=branch_target, dec_valid<=0, state->HALTED, halted<=1.
//     Capture resumes the following cycle from the target.
//   HALTED: no capture, PC_out holds. dec_valid drops to 0 when the last word transfers (dec_ready=1);
//     otherwise it is held. start is ignored.
//     branch_taken with target<PROG_LEN -> RUN at target, halted<=0, dec_valid<=0 (pending word flushed).
//     branch_taken with out-of-range target: PC_out<=target, dec_valid<=0, remain HALTED.
//   start is ignored outside IDLE. dec_ready is ignored while dec_valid=0.
//   Fetch is opaque to the instruction: no condition-code evaluation and no decode of branch fields here.
// TESTING
//   1 Reset then start, dec_ready=1 held, PROG_LEN=8 -> dec_instr=32'hE3A11016 with dec_pc=0
//     one cycle after RUN entry; pc 1..7 follow back-to-back; halted=1 on the edge pc 7 is captured.
//   2 dec_ready=0 for 3 cycles while dec_pc=2 -> PC_out=3, dec_instr/dec_pc frozen;
//     on release pc 3 captured next edge, no word lost or duplicated.
//   3 branch_taken=1, branch_target=1 while dec_pc=4 -> dec_valid=0 one cycle,
//     then dec_pc=1 with dec_instr=32'hE3A22005.
//   4 Halted with dec_valid=1, dec_ready=0 -> word held; dec_ready=1 -> dec_valid=0.
//     Then branch_target=0 -> RUN, halted=0, pc 0 refetched.
//   5 branch_target=12 with PROG_LEN=8 -> halted=1 next edge, dec_valid=0, no further captures.
//   6 reset_n=0 mid-stall and again in HALTED -> all outputs return to reset values next edge;
//     start while RUN has no effect.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, reads instruction memory and holds one registered fetch slot for decode
module instruction_fetch_unit #(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 32,
   parameter int PROG_LEN = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic [ADDR_W-1:0] PC_out,
   input  logic [DATA_W-1:0] IR_out,
   output logic              dec_valid,
   output logic [DATA_W-1:0] dec_instr,
   output logic [ADDR_W-1:0] dec_pc,
   input  logic              dec_ready,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              halted
);
   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
   localparam logic [ADDR_W:0]   LEN  = (ADDR_W+1)'(PROG_LEN);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);
   state_t            state_q;
   logic [ADDR_W-1:0] pc_q, dpc_q;
   logic [DATA_W-1:0] instr_q;
   logic              valid_q, halted_q;
   logic              in_range, slot_free;
   assign in_range  = {1'b0, branch_target} < LEN;
   assign slot_free = !valid_q || dec_ready;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         dpc_q    <= '0;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) state_q <= RUN;
            RUN: begin
               if (branch_taken) begin
                  pc_q    <= branch_target;
                  valid_q <= 1'b0;
                  if (!in_range) begin
                     state_q  <= HALTED;
                     halted_q <= 1'b1;
                  end
               end else if (slot_free) begin
                  instr_q <= IR_out;
                  dpc_q   <= pc_q;
                  valid_q <= 1'b1;
                  // the last program word parks the PC on itself
                  if (pc_q == LAST) begin
                     state_q  <= HALTED;
                     halted_q <= 1'b1;
                  end else pc_q <= pc_q + 1'b1;
               end
            end
            HALTED: begin
               if (branch_taken) begin
                  pc_q    <= branch_target;
                  valid_q <= 1'b0;
                  if (in_range) begin
                     state_q  <= RUN;
                     halted_q <= 1'b0;
                  end
               end else if (dec_ready) valid_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign PC_out    = pc_q;
   assign dec_valid = valid_q;
   assign dec_instr = instr_q;
   assign dec_pc    = dpc_q;
   assign halted    = halted_q;
endmodule
